// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue/writeback controller and the alu it feeds.
// One opcode enum keeps both blocks in agreement on the select codes.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } exec_state_e;

    // Codes 0, 6 and 7 have no ALU meaning.
    function automatic logic is_legal(input logic [2:0] op);
        logic ok_s;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: ok_s = 1'b1;
            default:                               ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction-in and result-out handshakes of alu_exec_ctrl.
// master = instruction producer / result consumer, slave = the controller.
interface alu_exec_ctrl_if import alu_pkg::*; #(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          in_imm_en;
    logic [DW-1:0] in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_rd;
    logic          out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_err
    );
endinterface

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two operand read ports, one debug read port,
// one synchronous write port; r0 reads as zero and is never written.
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    output logic [DATA_W-1:0]        rdata1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [DATA_W-1:0]        rdata2,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);
    logic [DATA_W-1:0] regs_r [NREG];

    // Storage: async clear, writes to r0 dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata1   = (raddr1   == '0) ? '0 : regs_r[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : regs_r[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_r[dbg_addr];
endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback controller driving an external combinational alu:
// IDLE -> EXEC -> CAPT -> RESP for legal ops, IDLE -> RESP for illegal ones.
module alu_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_exec_ctrl_if.slave          bus,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [2:0]              alu_sel,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data
);
    import alu_pkg::*;

    localparam int AW = $clog2(NREG);

    exec_state_e       state_r, state_nxt_s;
    logic [DATA_W-1:0] alu_a_r, alu_b_r, out_data_r;
    logic [2:0]        alu_sel_r;
    logic [AW-1:0]     rd_r;
    logic              out_err_r, out_valid_r, in_ready_r;
    logic [DATA_W-1:0] rs1_data_s, rs2_data_s;
    logic              accept_s, legal_s, we_s;

    assign accept_s = (state_r == ST_IDLE) && bus.in_valid;
    assign legal_s  = is_legal(bus.in_op);
    assign we_s     = (state_r == ST_CAPT);

    alu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (we_s),
        .waddr    (rd_r),
        .wdata    (alu_out),
        .raddr1   (bus.in_rs1),
        .rdata1   (rs1_data_s),
        .raddr2   (bus.in_rs2),
        .rdata2   (rs2_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = legal_s ? ST_EXEC : ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_CAPT;
            ST_CAPT: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand launch, result capture and handshake flags, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_sel_r   <= 3'd0;
            rd_r        <= '0;
            out_data_r  <= '0;
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_RESP);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_a_r <= rs1_data_s;
                        alu_b_r <= bus.in_imm_en ? bus.in_imm : rs2_data_s;
                        rd_r    <= bus.in_rd;
                        if (legal_s) begin
                            alu_sel_r <= bus.in_op;
                            out_err_r <= 1'b0;
                        end else begin
                            alu_sel_r  <= 3'd0;
                            out_err_r  <= 1'b1;
                            out_data_r <= '0;
                        end
                    end
                end
                ST_CAPT: out_data_r <= alu_out;
                default: ;
            endcase
        end
    end

    assign alu_a         = alu_a_r;
    assign alu_b         = alu_b_r;
    assign alu_sel       = alu_sel_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_rd    = rd_r;
    assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: vector table plus scoreboard of results,
// then backpressure and reset-abort sequences.
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        imm_en;
        logic [15:0] imm;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        err;
    } res_t;

    localparam int NV = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_a, alu_b, alu_out, dbg_data;
    logic [2:0]  alu_sel, dbg_addr;
    int          tests = 0;
    int          fails = 0;
    res_t        sb_q[$];
    logic [15:0] rf_m [8];
    vec_t        vt [NV];
    int          lat;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational alu.
    always_comb begin
        case (alu_sel)
            3'd1:    alu_out = alu_a + alu_b;
            3'd2:    alu_out = alu_a - alu_b;
            3'd3:    alu_out = alu_a & alu_b;
            3'd4:    alu_out = alu_a | alu_b;
            3'd5:    alu_out = alu_a ^ alu_b;
            default: alu_out = 16'h0000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Result monitor: pop expected entry on every completed output handshake.
    always @(negedge clk) begin
        res_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_rd",   32'(bus.out_rd),   32'(e.rd));
                check("out_err",  32'(bus.out_err),  32'(e.err));
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.in_op     = v.op;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_imm_en = v.imm_en;
        bus.in_imm    = v.imm;
    endtask

    // Offer one instruction, record its expected result, return cycles until out_valid.
    task automatic issue(input vec_t v, output int cycles);
        res_t r;
        @(posedge clk); #1;
        drive(v);
        r.data = v.exp_data;
        r.rd   = v.rd;
        r.err  = v.exp_err;
        sb_q.push_back(r);
        @(negedge clk);
        for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.out_valid && cycles < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0AB0, 16'h0AB0, 1'b0};
        vt[1]  = '{OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h01AC, 16'h01AC, 1'b0};
        vt[2]  = '{OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0C5C, 1'b0};
        vt[3]  = '{OP_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0904, 1'b0};
        vt[4]  = '{OP_AND, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h00A0, 1'b0};
        vt[5]  = '{OP_OR,  3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0BBC, 1'b0};
        vt[6]  = '{OP_XOR, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0B1C, 1'b0};
        vt[7]  = '{OP_SUB, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0001, 16'hFFFF, 1'b0};
        vt[8]  = '{OP_ADD, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0001, 16'h0000, 1'b0};
        vt[9]  = '{OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 16'h0005, 16'h0AB5, 1'b0};
        vt[10] = '{3'd6,   3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vt[11] = '{3'd0,   3'd6, 3'd1, 3'd2, 1'b1, 16'h1111, 16'h0000, 1'b1};
        for (int r = 0; r < 8; r++) rf_m[r] = 16'h0000;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rd = 3'd0; bus.in_rs1 = 3'd0;
        bus.in_rs2 = 3'd0; bus.in_imm_en = 1'b0; bus.in_imm = 16'h0000;
        bus.out_ready = 1'b1;
        dbg_addr = 3'd0;
        #12;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_rd",    32'(bus.out_rd),    32'd0);
        check("rst_alu_a",     32'(alu_a),         32'd0);
        check("rst_alu_b",     32'(alu_b),         32'd0);
        check("rst_alu_sel",   32'(alu_sel),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(vt[i], lat);
            check($sformatf("latency[%0d]", i), 32'(lat), vt[i].exp_err ? 32'd1 : 32'd3);
            check($sformatf("alu_sel[%0d]", i), 32'(alu_sel), vt[i].exp_err ? 32'd0 : 32'(vt[i].op));
            @(posedge clk); #1;
            if (!vt[i].exp_err && vt[i].rd != 3'd0) rf_m[vt[i].rd] = vt[i].exp_data;
            dbg_addr = vt[i].rd;
            #1;
            check($sformatf("rf_after[%0d]", i), 32'(dbg_data), 32'(rf_m[vt[i].rd]));
        end
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check($sformatf("rf_sweep[r%0d]", r), 32'(dbg_data), 32'(rf_m[r]));
        end

        // Backpressure: result held while a second instruction is offered and ignored.
        bus.out_ready = 1'b0;
        issue('{OP_AND, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h00A0, 1'b0}, lat);
        check("bp_latency", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive('{OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h0000, 1'b0});
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_data",  32'(bus.out_data),  32'h00A0);
            check("bp_out_rd",    32'(bus.out_rd),    32'd7);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rf_m[7] = 16'h00A0;
        check("bp_back_idle", 32'(bus.in_ready),  32'd1);
        check("bp_valid_low", 32'(bus.out_valid), 32'd0);
        dbg_addr = 3'd7; #1;
        check("bp_rf_r7", 32'(dbg_data), 32'(rf_m[7]));
        dbg_addr = 3'd6; #1;
        check("bp_rf_r6_untouched", 32'(dbg_data), 32'(rf_m[6]));
        check("sb_drained_bp", 32'(sb_q.size()), 32'd0);

        // Reset while the ADD into r4 is in EXEC.
        @(posedge clk); #1;
        drive('{OP_ADD, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0007, 16'h0AB7, 1'b0});
        @(negedge clk);
        check("abort_offer_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("abort_in_exec", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_data",  32'(bus.out_data),  32'd0);
        check("abort_alu_a",     32'(alu_a),         32'd0);
        check("abort_alu_sel",   32'(alu_sel),       32'd0);
        dbg_addr = 3'd1; #1;
        check("abort_rf_r1_clear", 32'(dbg_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dbg_addr = 3'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_result", 32'(bus.out_valid), 32'd0);
        end
        check("abort_rf_r4", 32'(dbg_data), 32'd0);
        check("sb_drained_end", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle issue/writeback controller that sits directly upstream of the 16-bit combinational `alu` and consumes its result. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file. It drives the ALU's `A`, `B` and `ALU_Sel` from registers, captures `ALU_Out`, writes it back, and presents the result downstream with a second valid/ready handshake.

## Interface
- `DATA_W`, default 16: operand and result width; must match `alu`.
- `NREG`, default 8: register-file entries; the address width is log2(NREG).
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: controller can accept an instruction.
- `in_op` in 3: ALU select code.
- `in_rd`, `in_rs1`, `in_rs2` in 3 each: destination and source register indices.
- `in_imm_en` in 1: when 1, B comes from `in_imm` instead of `rs2`.
- `in_imm` in DATA_W: immediate operand.
- `alu_a`, `alu_b` out DATA_W: registered operands to `alu`.
- `alu_sel` out 3: registered select to `alu`.
- `alu_out` in DATA_W: combinational result from `alu`.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out DATA_W: result value.
- `out_rd` out 3: destination written.
- `out_err` out 1: illegal opcode flag.
- `dbg_addr` in 3: register-file debug read index.
- `dbg_data` out DATA_W: combinational read of `rf[dbg_addr]`.

## Operation
- Opcodes: 1 ADD, 2 SUB (A-B), 3 AND, 4 OR, 5 XOR. Codes 0, 6 and 7 are illegal.
- All arithmetic is modulo 2^16. There are no carry or overflow outputs.
- `r0` is hardwired to 0. Writes to `r0` are dropped, but the result is still reported on `out_data`.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `rd`/`op`, load `alu_a`=rf[rs1] and `alu_b`=(imm_en ? imm : rf[rs2]), load `alu_sel`=op, then go to EXEC.
  - Illegal op: `alu_sel` forced to 0, go straight to RESP with `out_err`=1 and `out_data`=0, no writeback.
- EXEC: ALU inputs are stable for one full cycle; go to CAPT.
- CAPT: register `alu_out` into `out_data`, write rf[rd] (unless rd=0), go to RESP.
- RESP:
  - `out_valid`=1.
  - `out_data`, `out_rd` and `out_err` are held stable until `out_ready`=1.
  - On that cycle, return to IDLE.
- Read-after-write: the next instruction's operand read sees the written value, because the write completes before IDLE.
- `in_ready`=0 in every state except IDLE. Instructions offered while busy are not consumed.

## Timing
- Reset values: `in_ready`=1 (state IDLE), `out_valid`=0, `out_err`=0; `out_data`, `out_rd`, `alu_a`, `alu_b`, `alu_sel` all 0; every rf entry 0.
- Accept at edge N. Result captured at N+2. `out_valid` first high after N+2.
- Best-case throughput is one instruction per 4 cycles when `out_ready` is held high.
- Illegal op: `out_valid` high after edge N, with no EXEC or CAPT cycles.
- Asserting `rst` in any state aborts the instruction immediately:
  - no writeback occurs;
  - the FSM returns to IDLE;
  - all outputs return to their reset values.
- `out_ready` high while `out_valid`=0 has no effect.
- `dbg_data` is purely combinational. A same-cycle write is not bypassed.

## Structure
- Package `alu_pkg` holds:
  - the `alu_op_e` enum (codes 1..5 as named above, plus an `is_legal` function);
  - the `exec_state_e` FSM enum;
  - the `DATA_W` and `REG_AW` constants.
- `alu` imports the same `alu_op_e`, so both blocks share one encoding.
- Sub-module `alu_regfile`: NREG x DATA_W, two combinational read ports plus the debug read port, one synchronous write port, `r0` forced to zero, asynchronous clear on `rst`.

## Test plan
- Load immediates: ADD rd=1 rs1=0 imm=16'h0AB0, then rd=2 imm=16'h01AC. Required: `out_data` 0AB0 then 01AC; `dbg_data` correct for r1 and r2.
- ALU ops on r1,r2: ADD gives 0C5C, SUB gives 0904, AND gives 00A0, OR gives 0BBC, XOR gives 0B1C. Each `out_valid` rises exactly 3 cycles after acceptance.
- Wrap: r3=FFFF, then ADD r3+imm 1 gives 0000; SUB r0-imm 1 gives FFFF.
- Illegal op 6: `out_err`=1, `out_data`=0, `out_valid` the cycle after acceptance, rf unchanged.
- Backpressure: hold `out_ready`=0 for 5 cycles. Required: `out_valid`/`out_data` stable, `in_ready`=0, and a concurrent `in_valid` is ignored.
- Reset during EXEC of ADD into r4: r4 stays 0, `out_valid`=0, `in_ready`=1 immediately after `rst` asserts.
